// File: rtl/fly_formation_ctrl.sv
// fly_formation_ctrl: 17-fly formation march, kills, wave clear and respawn; FLY_SPEEDUP_EN scales move rate with survivors
module fly_formation_ctrl #(
  parameter int ORIGIN_X       = 64,
  parameter int ORIGIN_Y       = 40,
  parameter int SPACING_X      = 32,
  parameter int SPACING_Y      = 24,
  parameter int STEP_X         = 2,
  parameter int DROP_Y         = 8,
  parameter int MOVE_DIV       = 4,
  parameter int MAX_OFFSET_X   = 256,
  parameter int MAX_OFFSET_Y   = 200,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         frame_tick,
  input  logic         hit_valid,
  input  logic [4:0]   hit_idx,
  output logic         hit_ready,
  output logic [169:0] fly_x_flat,
  output logic [169:0] fly_y_flat,
  output logic [16:0]  fly_alive_flat,
  output logic [4:0]   alive_count,
  output logic         wave_clear
);
  localparam int N = 17;
  localparam int DW = $clog2(MOVE_DIV + 1);
  localparam int CW = $clog2(RESPAWN_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;
  state_t state, state_n;
  logic [9:0] off_x, off_x_n, off_y, off_y_n;
  logic dir, dir_n;
  logic [DW-1:0] div_cnt, div_cnt_n;
  logic [CW-1:0] clr_cnt, clr_cnt_n;
  logic [N-1:0] alive_n;
  logic [4:0] count_n;
  logic wave_clear_n, kill, move, edge_hit, respawn;
  int eff_div;
`ifdef FLY_SPEEDUP_EN
  localparam int D2 = (MOVE_DIV >> 1) < 1 ? 1 : (MOVE_DIV >> 1);
  localparam int D4 = (MOVE_DIV >> 2) < 1 ? 1 : (MOVE_DIV >> 2);
  assign eff_div = alive_count > 5'd8 ? MOVE_DIV : alive_count > 5'd2 ? D2 : D4;
`else
  assign eff_div = MOVE_DIV;
`endif
  assign hit_ready = state == RUN;
  assign kill = hit_valid && hit_ready && hit_idx < 5'(N) && fly_alive_flat[hit_idx];
  assign move = state == RUN && frame_tick && int'(div_cnt) >= eff_div - 1;
  assign edge_hit = dir ? off_x < 10'(STEP_X) : int'(off_x) + STEP_X > MAX_OFFSET_X;
  assign respawn = (state == IDLE && start) ||
                   (state == CLEAR && frame_tick && int'(clr_cnt) == RESPAWN_FRAMES - 1);
  always_comb begin
    state_n = state;
    off_x_n = off_x;
    off_y_n = off_y;
    dir_n = dir;
    div_cnt_n = div_cnt;
    clr_cnt_n = clr_cnt;
    alive_n = fly_alive_flat;
    count_n = alive_count;
    wave_clear_n = 1'b0;
    if (respawn) begin
      state_n = RUN;
      off_x_n = '0;
      off_y_n = '0;
      dir_n = 1'b0;
      div_cnt_n = '0;
      clr_cnt_n = '0;
      alive_n = '1;
      count_n = 5'(N);
    end else if (state == CLEAR && frame_tick) begin
      clr_cnt_n = clr_cnt + 1'b1;
    end else if (state == RUN) begin
      if (frame_tick) div_cnt_n = move ? '0 : div_cnt + 1'b1;
      // a bounce drops the formation instead of moving it sideways
      if (move && edge_hit) begin
        dir_n = !dir;
        off_y_n = int'(off_y) + DROP_Y > MAX_OFFSET_Y ? 10'(MAX_OFFSET_Y) : off_y + 10'(DROP_Y);
      end else if (move) begin
        off_x_n = dir ? off_x - 10'(STEP_X) : off_x + 10'(STEP_X);
      end
      if (kill) begin
        alive_n = fly_alive_flat & ~(N'(kill) << hit_idx);
        count_n = alive_count - 1'b1;
        state_n = alive_count == 5'd1 ? CLEAR : RUN;
        wave_clear_n = alive_count == 5'd1;
        clr_cnt_n = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      off_x <= '0;
      off_y <= '0;
      dir <= 1'b0;
      div_cnt <= '0;
      clr_cnt <= '0;
      fly_alive_flat <= '0;
      alive_count <= '0;
      wave_clear <= 1'b0;
    end else begin
      state <= state_n;
      off_x <= off_x_n;
      off_y <= off_y_n;
      dir <= dir_n;
      div_cnt <= div_cnt_n;
      clr_cnt <= clr_cnt_n;
      fly_alive_flat <= alive_n;
      alive_count <= count_n;
      wave_clear <= wave_clear_n;
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_pos
    assign fly_x_flat[10*i +: 10] = 10'(ORIGIN_X + (i % 6) * SPACING_X) + off_x;
    assign fly_y_flat[10*i +: 10] = 10'(ORIGIN_Y + (i / 6) * SPACING_Y) + off_y;
  end
endmodule

// File: tb/tb_fly_formation_ctrl.sv
// tb_fly_formation_ctrl: vector table, corner sequences and randomized run against a reference model
module tb_fly_formation_ctrl;
  localparam int MOVE_DIV = 4, STEP_X = 2, DROP_Y = 8, MAX_OX = 256, MAX_OY = 200, RESPAWN = 60;
  logic clk = 0, rst_n = 0, start = 0, frame_tick = 0, hit_valid = 0;
  logic [4:0] hit_idx = 0;
  logic hit_ready, wave_clear;
  logic [169:0] fly_x_flat, fly_y_flat;
  logic [16:0] fly_alive_flat;
  logic [4:0] alive_count;
  int n_chk = 0, n_fail = 0;
  int m_st, m_ox, m_oy, m_dir, m_div, m_clr;
  logic [16:0] m_alive;
  bit m_wc;
  typedef struct {
    bit st, tk, hv;
    logic [4:0] idx;
    logic [16:0] alive;
    logic [4:0] cnt;
    bit rdy;
    logic [9:0] x0, y0;
  } tv_t;
  tv_t tv[11];

  always #5 clk = ~clk;

  fly_formation_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_tick(frame_tick),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .hit_ready(hit_ready),
    .fly_x_flat(fly_x_flat), .fly_y_flat(fly_y_flat),
    .fly_alive_flat(fly_alive_flat), .alive_count(alive_count), .wave_clear(wave_clear)
  );

  task automatic chk(input string nm, input logic [169:0] act, input logic [169:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [169:0] grid(input int base, input int pitch, input int per_col, input int off);
    logic [169:0] r;
    for (int i = 0; i < 17; i++)
      r[10*i +: 10] = 10'(base + (per_col ? i % 6 : i / 6) * pitch + off);
    return r;
  endfunction

  function automatic int eff_div();
    int c = $countones(m_alive);
`ifdef FLY_SPEEDUP_EN
    int d = c > 8 ? MOVE_DIV : c > 2 ? MOVE_DIV / 2 : MOVE_DIV / 4;
    return d < 1 ? 1 : d;
`else
    return c >= 0 ? MOVE_DIV : MOVE_DIV;
`endif
  endfunction

  task automatic model_reset();
    m_st = 0; m_ox = 0; m_oy = 0; m_dir = 0; m_div = 0; m_clr = 0; m_alive = '0; m_wc = 0;
  endtask

  task automatic spawn();
    m_st = 1; m_ox = 0; m_oy = 0; m_dir = 0; m_div = 0; m_clr = 0; m_alive = '1;
  endtask

  task automatic model_step();
    int ed;
    m_wc = 0;
    if (m_st == 0) begin
      if (start) spawn();
    end else if (m_st == 2) begin
      if (frame_tick) begin
        m_clr++;
        if (m_clr == RESPAWN) spawn();
      end
    end else begin
      ed = eff_div();
      if (frame_tick) begin
        m_div++;
        if (m_div >= ed) begin
          m_div = 0;
          if (m_dir == 0 ? m_ox + STEP_X > MAX_OX : m_ox < STEP_X) begin
            m_dir = 1 - m_dir;
            m_oy = m_oy + DROP_Y > MAX_OY ? MAX_OY : m_oy + DROP_Y;
          end else m_ox = m_dir == 0 ? m_ox + STEP_X : m_ox - STEP_X;
        end
      end
      if (hit_valid && hit_idx < 17 && m_alive[hit_idx]) begin
        m_alive[hit_idx] = 1'b0;
        if (m_alive == 0) begin m_st = 2; m_clr = 0; m_wc = 1; end
      end
    end
  endtask

  task automatic check_model();
    chk("alive", fly_alive_flat, m_alive);
    chk("count", alive_count, $countones(m_alive));
    chk("ready", hit_ready, m_st == 1);
    chk("wave_clear", wave_clear, m_wc);
    chk("x_grid", fly_x_flat, grid(64, 32, 1, m_ox));
    chk("y_grid", fly_y_flat, grid(40, 24, 0, m_oy));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 0; start = 0; frame_tick = 0; hit_valid = 0; hit_idx = 0;
    #2;
    model_reset();
    check_model();
    chk("rst_alive", fly_alive_flat, 17'h0);
    chk("rst_ready", hit_ready, 1'b0);
    chk("rst_x0", fly_x_flat[9:0], 10'd64);
    chk("rst_y0", fly_y_flat[9:0], 10'd40);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic drive(input bit st, input bit tk, input bit hv, input logic [4:0] idx);
    start = st; frame_tick = tk; hit_valid = hv; hit_idx = idx;
  endtask

  initial begin
    logic [9:0] xb;
    tv[0]  = '{0, 0, 0, 5'd0,  17'h00000, 5'd0,  0, 10'd64, 10'd40};
    tv[1]  = '{1, 0, 0, 5'd0,  17'h1FFFF, 5'd17, 1, 10'd64, 10'd40};
    tv[2]  = '{0, 1, 0, 5'd0,  17'h1FFFF, 5'd17, 1, 10'd64, 10'd40};
    tv[3]  = '{0, 1, 0, 5'd0,  17'h1FFFF, 5'd17, 1, 10'd64, 10'd40};
    tv[4]  = '{0, 1, 0, 5'd0,  17'h1FFFF, 5'd17, 1, 10'd64, 10'd40};
    tv[5]  = '{0, 1, 0, 5'd0,  17'h1FFFF, 5'd17, 1, 10'd66, 10'd40};
    tv[6]  = '{0, 0, 1, 5'd3,  17'h1FFF7, 5'd16, 1, 10'd66, 10'd40};
    tv[7]  = '{0, 0, 1, 5'd3,  17'h1FFF7, 5'd16, 1, 10'd66, 10'd40};
    tv[8]  = '{0, 0, 1, 5'd20, 17'h1FFF7, 5'd16, 1, 10'd66, 10'd40};
    tv[9]  = '{1, 0, 0, 5'd0,  17'h1FFF7, 5'd16, 1, 10'd66, 10'd40};
    tv[10] = '{0, 1, 1, 5'd0,  17'h1FFF6, 5'd15, 1, 10'd66, 10'd40};
    do_reset();
    for (int k = 0; k < 11; k++) begin
      drive(tv[k].st, tv[k].tk, tv[k].hv, tv[k].idx);
      cyc();
      chk("tv_alive", fly_alive_flat, tv[k].alive);
      chk("tv_count", alive_count, tv[k].cnt);
      chk("tv_ready", hit_ready, tv[k].rdy);
      chk("tv_x0", fly_x_flat[9:0], tv[k].x0);
      chk("tv_y0", fly_y_flat[9:0], tv[k].y0);
      if (k == 1) begin
        chk("fly7_x", fly_x_flat[79:70], 10'd96);
        chk("fly7_y", fly_y_flat[79:70], 10'd64);
      end
    end
    // march to the right edge and bounce
    do_reset();
    drive(1, 0, 0, 0); cyc();
    drive(0, 1, 0, 0);
    for (int k = 0; k < 512; k++) cyc();
    chk("edge_x0", fly_x_flat[9:0], 10'd320);
    for (int k = 0; k < 4; k++) cyc();
    chk("bounce_x0", fly_x_flat[9:0], 10'd320);
    chk("bounce_y0", fly_y_flat[9:0], 10'd48);
    for (int k = 0; k < 4; k++) cyc();
    chk("left_x0", fly_x_flat[9:0], 10'd318);
    // kill everything, last kill lands on a move tick
    for (int k = 0; k < 16; k++) begin drive(0, 0, 1, 5'(k)); cyc(); end
    drive(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc();
    xb = fly_x_flat[9:0];
    drive(0, 1, 1, 5'd16); cyc();
    chk("last_kill_move", fly_x_flat[9:0], xb - 10'd2);
    chk("last_kill_wc", wave_clear, 1'b1);
    chk("last_kill_ready", hit_ready, 1'b0);
    drive(0, 1, 0, 0);
    for (int k = 0; k < 59; k++) begin
      cyc();
      if (k == 0) chk("wc_one_cycle", wave_clear, 1'b0);
    end
    chk("clear_alive", fly_alive_flat, 17'h0);
    cyc();
    chk("respawn_alive", fly_alive_flat, 17'h1FFFF);
    chk("respawn_x0", fly_x_flat[9:0], 10'd64);
    chk("respawn_y0", fly_y_flat[9:0], 10'd40);
    // two survivors: move rate
    for (int k = 0; k < 15; k++) begin drive(0, 0, 1, 5'(k)); cyc(); end
    drive(0, 1, 0, 0); cyc();
`ifdef FLY_SPEEDUP_EN
    chk("speedup_x0", fly_x_flat[9:0], 10'd66);
`else
    chk("fixed_div_x0", fly_x_flat[9:0], 10'd64);
`endif
    cyc(); cyc();
    do_reset();
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0 ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16)));
      cyc();
      if ($urandom_range(0, 999) == 0) do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
